// File: rtl/alu_serial_rx.sv
// Serial deserializer: assembles 11-bit packets into {B, A, op} frames for the ALU.
// Define ALU_RX_TIMEOUT_EN to abort a partial frame after TIMEOUT_CYCLES idle cycles.
module alu_serial_rx #(
    parameter int DATA_PACKETS   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        frame_busy
);

    typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

    state_t      state_q;
    logic [2:0]  bit_q;
    logic        type_q;
    logic [7:0]  pay_q;
    logic [3:0]  pkt_q;
    logic [63:0] ba_q;
    logic [3:0]  crc_q;

    logic [3:0]  crc_data_d;
    logic [3:0]  crc_cmd_d;
    logic        full_d;
    logic        crc_ok_d;
    logic        op_ok_d;

    // MSB-first CRC4 (x^4+x+1) over the low n bits of d
    function automatic logic [3:0] crc_shift(input logic [3:0] c,
                                             input logic [7:0] d,
                                             input int n);
        logic [3:0] r;
        r = c;
        for (int i = n - 1; i >= 0; i--) begin
            r = {r[2:0], 1'b0} ^ ((r[3] ^ d[i]) ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    assign crc_data_d = crc_shift(crc_q, pay_q, 8);
    assign crc_cmd_d  = crc_shift(crc_q, {4'b0000, 1'b1, pay_q[6:4]}, 4);
    assign full_d     = (pkt_q == 4'(DATA_PACKETS));
    assign crc_ok_d   = (crc_cmd_d == pay_q[3:0]);
    assign op_ok_d    = pay_q[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101};

`ifdef ALU_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            type_q     <= 1'b0;
            pay_q      <= '0;
            pkt_q      <= '0;
            ba_q       <= '0;
            crc_q      <= '0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_op     <= '0;
            err_data   <= 1'b0;
            err_crc    <= 1'b0;
            err_op     <= 1'b0;
            frame_busy <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (out_valid) frame_busy <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_q    <= TYPE;
                        frame_busy <= 1'b1;
                    end
                end
                TYPE: begin
                    type_q  <= sin;
                    bit_q   <= '0;
                    state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    pay_q <= {pay_q[6:0], sin};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= STOP;
                end
                STOP: begin
                    state_q <= IDLE;
                    if (!sin || type_q) begin
                        // frame ends: broken stop bit or command packet
                        out_valid  <= 1'b1;
                        frame_busy <= 1'b1;
                        out_a      <= ba_q[31:0];
                        out_b      <= ba_q[63:32];
                        out_op     <= pay_q[6:4];
                        err_data   <= !sin || !full_d;
                        err_crc    <= sin && full_d && !crc_ok_d;
                        err_op     <= sin && full_d && crc_ok_d && !op_ok_d;
                        pkt_q      <= '0;
                        ba_q       <= '0;
                        crc_q      <= '0;
                    end else begin
                        ba_q  <= {ba_q[55:0], pay_q};
                        crc_q <= crc_data_d;
                        if (pkt_q != 4'(DATA_PACKETS + 1)) pkt_q <= pkt_q + 4'd1;
                    end
                end
            endcase
`ifdef ALU_RX_TIMEOUT_EN
            if (state_q == IDLE && pkt_q != '0 && sin) begin
                if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    out_valid <= 1'b1;
                    out_a     <= ba_q[31:0];
                    out_b     <= ba_q[63:32];
                    err_data  <= 1'b1;
                    err_crc   <= 1'b0;
                    err_op    <= 1'b0;
                    pkt_q     <= '0;
                    ba_q      <= '0;
                    crc_q     <= '0;
                    idle_q    <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end else begin
                idle_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: vector table, hand sequences, random frames.
// Expected values come from a polynomial-division CRC model and the frame rules.
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic        frame_busy;

    alu_serial_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .err_data  (err_data),
        .err_crc   (err_crc),
        .err_op    (err_op),
        .frame_busy(frame_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  errs;
        logic        busy;
    } ev_t;

    ev_t evq[$];
    ev_t mon_e;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_e.cyc  = cyc;
            mon_e.a    = out_a;
            mon_e.b    = out_b;
            mon_e.op   = out_op;
            mon_e.errs = {err_data, err_crc, err_op};
            mon_e.busy = frame_busy;
            evq.push_back(mon_e);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // CRC as remainder of ({B,A,1,op} * x^4) divided by x^4+x+1
    function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                             input logic [2:0] op);
        logic [71:0] v;
        logic [71:0] p;
        v = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            p = 72'h13;
            if (v[i]) v = v ^ (p << (i - 4));
        end
        return v[3:0];
    endfunction

    function automatic logic [2:0] model_err(input int nd, input logic flip, input logic [2:0] op);
        if (nd != 8) return 3'b100;
        if (flip) return 3'b010;
        if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) return 3'b001;
        return 3'b000;
    endfunction

    task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stp);
        logic [10:0] bits;
        bits = {1'b0, typ, pl, stp};
        for (int i = 10; i >= 0; i--) begin
            sin = bits[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int nd);
        logic [63:0] ba;
        logic [7:0]  by;
        ba = {b, a};
        for (int k = 0; k < nd; k++) begin
            by = (k < 8) ? ba[63 - 8*k -: 8] : 8'h5A;
            send_pkt(1'b0, by, 1'b1);
        end
    endtask

    task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input logic flip, input int nd, output int stop_cyc);
        logic [3:0] crc;
        send_data(b, a, nd);
        crc = model_crc(b, a, op) ^ {3'b000, flip};
        send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
        stop_cyc = cyc;
        sin = 1'b1;
    endtask

    task automatic expect_ev(input string name, input int ecyc, input logic [31:0] b,
                             input logic [31:0] a, input logic [2:0] op,
                             input logic [2:0] errs, input int maxw);
        ev_t e;
        int  n;
        n = 0;
        while (evq.size() == 0 && n < maxw) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (evq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_valid got=none exp=pulse", name);
            return;
        end
        e = evq.pop_front();
        chk($sformatf("%s_cyc", name), 64'(e.cyc), 64'(ecyc));
        chk($sformatf("%s_err", name), 64'(e.errs), 64'(errs));
        chk($sformatf("%s_busy", name), 64'(e.busy), 64'd1);
        if (!errs[2]) begin
            chk($sformatf("%s_ab", name), {e.a, e.b}, {a, b});
            chk($sformatf("%s_op", name), 64'(e.op), 64'(op));
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk($sformatf("%s_pulse", name), 64'(out_valid), 64'd0);
        chk($sformatf("%s_idle", name), 64'(frame_busy), 64'd0);
    endtask

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic        flip;
        int          nd;
        logic [2:0]  errs;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int c1;
        logic [31:0] rb;
        logic [31:0] ra;
        logic [2:0]  rop;
        logic        rfl;
        int          rnd;

        tbl[0] = '{32'h00000003, 32'h00000005, 3'b100, 1'b0, 8, 3'b000};
        tbl[1] = '{32'h00000003, 32'h00000005, 3'b100, 1'b1, 8, 3'b010};
        tbl[2] = '{32'h00000003, 32'h00000005, 3'b100, 1'b0, 7, 3'b100};
        tbl[3] = '{32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 1'b0, 8, 3'b000};
        tbl[4] = '{32'hDEADBEEF, 32'h01234567, 3'b011, 1'b0, 8, 3'b001};
        tbl[5] = '{32'h11111111, 32'h22222222, 3'b101, 1'b0, 9, 3'b100};
        tbl[6] = '{32'h80000001, 32'h7FFFFFFE, 3'b101, 1'b0, 8, 3'b000};
        tbl[7] = '{32'hCAFEF00D, 32'h00000000, 3'b111, 1'b1, 8, 3'b010};
        tbl[8] = '{32'h55AA55AA, 32'hAA55AA55, 3'b110, 1'b1, 7, 3'b100};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ab", {out_a, out_b}, 64'd0);
        chk("rst_ctl", 64'({out_valid, out_op, err_data, err_crc, err_op, frame_busy}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            send_frame(tbl[i].b, tbl[i].a, tbl[i].op, tbl[i].flip, tbl[i].nd, sc);
            expect_ev($sformatf("vec%0d", i), sc, tbl[i].b, tbl[i].a, tbl[i].op, tbl[i].errs, 20);
            idle_check($sformatf("vec%0d", i));
        end

        // reset in the middle of a frame, then a clean OR frame
        send_data(32'hA5A5A5A5, 32'h3C3C3C3C, 4);
        sin = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ab", {out_a, out_b}, 64'd0);
        chk("midrst_ctl", 64'({out_valid, out_op, err_data, err_crc, err_op, frame_busy}), 64'd0);
        rst_n = 1'b1;
        chk("midrst_nopulse", 64'(evq.size()), 64'd0);
        send_frame(32'h12345678, 32'h9ABCDEF0, 3'b001, 1'b0, 8, sc);
        expect_ev("or_after_rst", sc, 32'h12345678, 32'h9ABCDEF0, 3'b001, 3'b000, 20);
        idle_check("or_after_rst");

        // broken stop bit, immediately followed by a full frame
        send_pkt(1'b0, 8'hA5, 1'b0);
        c1 = cyc;
        send_frame(32'h00C0FFEE, 32'hBADC0DE5, 3'b101, 1'b0, 8, sc);
        expect_ev("stoperr", c1, 32'h0, 32'h0, 3'b000, 3'b100, 20);
        expect_ev("after_stoperr", sc, 32'h00C0FFEE, 32'hBADC0DE5, 3'b101, 3'b000, 20);
        idle_check("after_stoperr");

        for (int r = 0; r < 20; r++) begin
            rb  = $urandom;
            ra  = $urandom;
            rop = 3'($urandom_range(0, 7));
            rfl = ($urandom_range(0, 3) == 0);
            rnd = 8;
            if ($urandom_range(0, 4) == 0) rnd = ($urandom_range(0, 1) == 0) ? 7 : 9;
            send_frame(rb, ra, rop, rfl, rnd, sc);
            expect_ev($sformatf("rnd%0d", r), sc, rb, ra, rop, model_err(rnd, rfl, rop), 20);
            idle_check($sformatf("rnd%0d", r));
        end

`ifdef ALU_RX_TIMEOUT_EN
        send_data(32'h01020304, 32'h05060708, 3);
        c1 = cyc;
        sin = 1'b1;
        expect_ev("timeout", c1 + 255, 32'h0, 32'h0, 3'b000, 3'b100, 300);
        idle_check("timeout");
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("no_extra_pulse", 64'(evq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Serial input deserializer in front of the ALU core.
- Samples the 1-bit `sin` line, assembles 11-bit packets into one operation frame: 8 data packets (B bytes, then A bytes, MSB first) followed by 1 command packet.
- Checks framing, opcode and CRC4.
- Presents A, B, opcode and error flags to the ALU core with a single-cycle valid pulse.

Parameters:
- DATA_PACKETS, 8, data packets per frame (fixed protocol value; only 8 supported).
- TIMEOUT_CYCLES, 255, idle cycles between packets before a mid-frame abort (used only with ALU_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- sin  in  1  serial input; idle high; one bit per clk.
- out_valid  out  1  one-cycle pulse: frame complete, outputs updated.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_op  out  3  opcode from command packet.
- err_data  out  1  wrong packet count or stop-bit error in frame.
- err_crc  out  1  CRC4 mismatch.
- err_op  out  1  opcode not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
- frame_busy  out  1  high while a frame is partially received.

Behaviour:
- Packet format (11 bits, in order): start=0, type (0=data, 1=cmd), 8 payload bits MSB first, stop=1.
- Command payload: {1'b0, op[2:0], crc[3:0]}.
- `sin` is sampled on every posedge clk.
- Packet FSM states: IDLE, TYPE, PAYLOAD (counter 0..7), STOP.
  - IDLE -> TYPE when sin==0.
  - TYPE -> PAYLOAD.
  - PAYLOAD shifts 8 bits, then -> STOP.
  - STOP -> IDLE.
- Frame logic uses a packet counter 0..9; it saturates at 9, meaning overflow.
  - Data packet with good stop bit: payload is shifted into a 64-bit {B,A} register; counter increments.
  - Command packet with good stop bit: frame ends.
- Stop bit sampled 0:
  - err_data=1, out_valid pulses, frame is aborted.
  - Counter clears; FSM returns to IDLE.
  - That bit is consumed; it is not treated as a new start bit.
- CRC4: polynomial x^4+x+1, init 0000, computed MSB first over the 68-bit vector {B, A, 1'b1, op}. Compare against crc[3:0].
- Error evaluation at command end:
  - err_data = (counter != 8).
  - err_crc is evaluated only if !err_data.
  - err_op is evaluated only if !err_data && !err_crc.
  - At most one error flag is set.
- Latency: out_valid asserts in the cycle after the posedge that sampled the command stop bit. out_a, out_b, out_op and the error flags update in the same cycle.
- All outputs hold until the next out_valid. out_valid is high for exactly 1 cycle. There is no backpressure.
- On err_data, out_a, out_b and out_op still reflect the register contents. The consumer ignores them.
- frame_busy: 1 from the first start bit of a frame until the out_valid cycle (inclusive); 0 otherwise.
- A new start bit is accepted in the cycle directly after STOP (back-to-back packets, no idle bit required).
- Reset (rst_n==0 at posedge), including mid-frame:
  - FSM goes to IDLE; counters, {B,A} and CRC state clear.
  - All outputs go to 0.
  - A partial frame is discarded with no out_valid.

Optional Feature:
- Macro: ALU_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while FSM==IDLE and the packet counter is > 0.
  - When the counter reaches TIMEOUT_CYCLES, the frame aborts: err_data=1 and out_valid pulses for 1 cycle, counters clear.
  - The idle counter resets on every start bit.
- Undefined: no timeout; a partial frame waits indefinitely.

Test Plan:
- Basic ADD frame:
  - Stimulus: B=0x00000003, A=0x00000005, op=100, CRC from golden model, packets back-to-back.
  - Required: out_valid 1 cycle after the cmd stop bit; out_b=0x00000003, out_a=0x00000005, out_op=100; all errors 0.
- CRC error:
  - Stimulus: same frame, crc bit 0 inverted.
  - Required: err_crc=1, err_data=0, err_op=0.
- Short frame:
  - Stimulus: 7 data packets, then a valid cmd packet.
  - Required: err_data=1 only. Then a full AND frame (B=0xFFFF0000, A=0x0F0F0F0F, op=000) decodes clean.
- Bad opcode:
  - Stimulus: op=011 with correct CRC.
  - Required: err_op=1, out_op=011.
- Reset mid-frame:
  - Stimulus: rst_n low for 1 cycle after 4 data packets, then a full OR frame (B=0x12345678, A=0x9ABCDEF0).
  - Required: no out_valid from the partial frame; all outputs 0 during reset; the OR frame decodes clean.
- Timeout (ALU_RX_TIMEOUT_EN, TIMEOUT_CYCLES=255):
  - Stimulus: 3 data packets, then sin held high.
  - Required: err_data pulse after 255 idle cycles; frame_busy drops.
